dac_tx: RTL and testbench
=========================

# dac_tx

- Transmit-side serializer for the audio path: it is the counterpart of the channel-strip input deserializer.
- Accepts signed 16-bit left/right sample pairs through a valid/ready handshake and buffers one pair.
- Shifts each pair out MSB-first on `serialOut`, left word then right word, 32 `BCLK` cycles per frame.
- Generates `LRCK` and `WCLK` framing so a codec DAC, or the input deserializer in loopback, can recover both words.

## Interface
Parameters: none (word width fixed at 16, frame fixed at 32 bits).

- `BCLK`  in  1  bit clock, sole clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `leftIn`  in  16  signed left sample, qualified by `sampleValid`
- `rightIn`  in  16  signed right sample, qualified by `sampleValid`
- `sampleValid`  in  1  upstream has a sample pair
- `sampleReady`  out  1  holding register empty; pair transfers on a rising edge with `sampleValid && sampleReady`
- `serialOut`  out  1  serial data, MSB first
- `LRCK`  out  1  channel select: 1 = left word, 0 = right word
- `WCLK`  out  1  word strobe, high during the last bit (bit 0) of each word
- `underrun`  out  1  one-cycle pulse: a frame started with no new pair available

## Operation
- One clock (`BCLK`); reset is asynchronous and active-low (`reset_n`).
- State:
  - `bitCnt` 5 bits, 0..31; 0–15 left word, 16–31 right word.
  - `hold` 32-bit holding register plus `holdFull` flag.
  - `shift` 32-bit shift register.
  - `lastFrame` 32-bit copy of the frame most recently loaded.
- Handshake:
  - `sampleReady = ~holdFull`, combinational from a register.
  - On transfer: `hold ← {leftIn, rightIn}`, `holdFull ← 1`.
  - `sampleValid` may drop at any time without a transfer; no combinational path from `sampleValid` to `sampleReady`.
- Frame boundary (edge with `bitCnt == 31`):
  - `bitCnt ← 0`.
  - If `holdFull`: `shift ← hold`, `lastFrame ← hold`, `holdFull ← 0`.
  - Else this is an underrun: `shift ←` underrun frame (see Configuration), `underrun ← 1` for one cycle.
  - A transfer cannot coincide with a load: `sampleReady` is 0 whenever `holdFull` is 1.
  - A transfer on the boundary edge with `holdFull == 0` fills `hold` and is used at the next boundary.
- Other edges: `bitCnt ← bitCnt + 1`; `shift ← shift << 1`, zero fill.
- Outputs are all registered or taken directly from registers:
  - `serialOut = shift[31]`.
  - `LRCK` is 1 while `bitCnt` ∈ 0..15, 0 while 16..31.
  - `WCLK` is 1 while `bitCnt` ∈ {15, 31}.
- No arithmetic on sample data: bits pass unmodified, two's complement preserved.

## Timing
- Reset values:
  - `bitCnt=0`, `shift=0`, `hold=0`, `holdFull=0`, `lastFrame=0`.
  - Outputs: `serialOut=0`, `LRCK=1`, `WCLK=0`, `underrun=0`, `sampleReady=1`.
  - A zero frame is therefore in progress at reset release.
- Reset mid-frame aborts the frame immediately:
  - Buffered pair discarded.
  - After release, framing restarts at `bitCnt=0`.
- Latency: a pair accepted at edge N appears as `serialOut = leftIn[15]` immediately after the first boundary edge at or after N+1.
  - Worst case 32 cycles of wait, plus one frame if `hold` was already full.
- Frame relationships relative to the boundary edge B:
  - `LRCK` rises after B and falls after B+16.
  - `WCLK` is high during cycles B+15 and B+31.
  - `leftIn[k]` is driven during cycle B+(15−k); `rightIn[k]` during cycle B+(31−k).
- Throughput: one pair per 32 cycles. With `sampleValid` held high, `sampleReady` is high for exactly one cycle per frame, the cycle after B.
- `underrun` is high during the cycle following the boundary edge that underran.

## Configuration
- Macro: `DAC_TX_UNDERRUN_ZERO_EN`.
- Defined: underrun loads `shift ← 0` (silence). `lastFrame` is not updated by underruns.
- Undefined: underrun loads `shift ← lastFrame`, repeating the last real pair. After reset with no pair ever accepted, this is 0.
- `underrun` pulse behaviour is identical in both builds.

## Test plan
- Reset: assert `reset_n=0` mid-run.
  - Outputs go immediately to `serialOut=0`, `LRCK=1`, `WCLK=0`, `underrun=0`, `sampleReady=1`.
  - A pair buffered before reset is never transmitted.
- Single pair `leftIn=16'h8001`, `rightIn=16'h7FFE` accepted mid-frame:
  - Next frame `serialOut` = 1,0×14,1 during `LRCK=1`, then 0,1×14,0 during `LRCK=0`.
  - `WCLK` high on the 16th and 32nd bits.
- Streaming 8 pairs with `sampleValid` held high:
  - Exactly one transfer per 32 cycles, no `underrun` pulses.
  - Words serialized in order, bit-exact.
- Underrun after pair `16'h1234/16'hABCD`, `sampleValid=0`:
  - One `underrun` pulse per frame.
  - Next frame is `1234/ABCD` (undefined macro) or `0000/0000` (`DAC_TX_UNDERRUN_ZERO_EN`).
- Transfer on the boundary edge with `hold` empty:
  - The pair is held for one frame (`underrun` pulses for the current frame), then transmitted at the next boundary.
- Loopback into the input deserializer:
  - Randomized 1000 pairs recovered bit-exact on `leftOut`/`rightOut`.

Source files
------------

// File: rtl/dac_tx.sv
// dac_tx: transmit-side serializer for the audio path.
// Buffers one signed 16-bit left/right pair and sends it MSB-first on serialOut.
// The left word goes first, then the right word, in a 32-BCLK frame.
// LRCK and WCLK carry the framing so a codec DAC or the input deserializer can
// recover both words.
// Build option DAC_TX_UNDERRUN_ZERO_EN: when defined, an underrun frame is
// silence. When undefined, an underrun repeats the last real pair.
module dac_tx (
  input  logic        BCLK,
  input  logic        reset_n,
  input  logic [15:0] leftIn,
  input  logic [15:0] rightIn,
  input  logic        sampleValid,
  output logic        sampleReady,
  output logic        serialOut,
  output logic        LRCK,
  output logic        WCLK,
  output logic        underrun
);

  logic [4:0]  bit_cnt;
  logic [4:0]  next_cnt;
  logic [31:0] hold;
  logic        hold_full;
  logic [31:0] shift_reg;
  logic [31:0] last_frame;
  logic [31:0] underrun_frame;
  logic        boundary;
  logic        transfer;

  // Bit 31 is the last bit of the frame; the next edge starts a new frame.
  assign boundary = (bit_cnt == 5'd31);

  // sampleReady comes only from hold_full, so sampleValid has no combinational
  // path to it.
  assign sampleReady = ~hold_full;
  assign transfer    = sampleValid & ~hold_full;

  // The 5-bit counter wraps from 31 to 0 on its own.
  assign next_cnt  = bit_cnt + 5'd1;
  assign serialOut = shift_reg[31];

`ifdef DAC_TX_UNDERRUN_ZERO_EN
  assign underrun_frame = '0;
`else
  assign underrun_frame = last_frame;
`endif

  // Frame position counter and registered framing strobes.
  // NOTE: LRCK/WCLK are decoded from next_cnt and then registered, so each
  // strobe lines up with the bit_cnt value it describes without a decode glitch.
  always_ff @(posedge BCLK or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= 5'd0;
      LRCK    <= 1'b1;
      WCLK    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register in this block samples the pre-edge values.
      bit_cnt <= next_cnt;
      LRCK    <= ~next_cnt[4];
      WCLK    <= &next_cnt[3:0];
    end
  end

  // Holding register, shift register, last-frame copy and the underrun pulse.
  always_ff @(posedge BCLK or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the data registers are reset as well as the flags. This
      // discards a buffered pair and keeps the underrun repeat frame at zero
      // until the first real pair arrives.
      hold       <= '0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      last_frame <= '0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (boundary) begin
        if (hold_full) begin
          shift_reg  <= hold;
          last_frame <= hold;
          hold_full  <= 1'b0;
        end else begin
          shift_reg <= underrun_frame;
          underrun  <= 1'b1;
        end
      end else begin
        shift_reg <= {shift_reg[30:0], 1'b0};
      end
      // A transfer requires hold_full == 0, so it never collides with a load.
      if (transfer) begin
        hold      <= {leftIn, rightIn};
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_tx.sv
// tb_dac_tx: randomized and directed bench for dac_tx with a frame-level model.
module tb_dac_tx;

  logic        BCLK = 1'b0;
  logic        reset_n;
  logic [15:0] leftIn;
  logic [15:0] rightIn;
  logic        sampleValid;
  logic        sampleReady;
  logic        serialOut;
  logic        LRCK;
  logic        WCLK;
  logic        underrun;

  always #5 BCLK = ~BCLK;

  dac_tx dut (
    .BCLK        (BCLK),
    .reset_n     (reset_n),
    .leftIn      (leftIn),
    .rightIn     (rightIn),
    .sampleValid (sampleValid),
    .sampleReady (sampleReady),
    .serialOut   (serialOut),
    .LRCK        (LRCK),
    .WCLK        (WCLK),
    .underrun    (underrun)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

`ifdef DAC_TX_UNDERRUN_ZERO_EN
  localparam logic [31:0] REPEAT_1234 = 32'h0000_0000;
`else
  localparam logic [31:0] REPEAT_1234 = 32'h1234_ABCD;
`endif

  // Frame-level model.
  // m_pos is the bit position in the current frame.
  // m_frame is the 32-bit word being sent.
  // m_pend holds the buffered pair.
  int          m_pos   = 0;
  logic [31:0] m_frame = '0;
  logic [31:0] m_last  = '0;
  logic [31:0] m_pend[$];
  logic        m_und   = 1'b0;
  logic        m_real  = 1'b0;
  logic        m_xfer  = 1'b0;
  int          m_xfers = 0;

  always @(posedge BCLK or negedge reset_n) begin
    if (!reset_n) begin
      m_pos   = 0;
      m_frame = '0;
      m_last  = '0;
      m_pend.delete();
      m_und   = 1'b0;
      m_real  = 1'b0;
    end else begin
      m_xfer = sampleValid && (m_pend.size() == 0);
      if (m_pos == 31) begin
        m_pos = 0;
        if (m_pend.size() > 0) begin
          m_frame = m_pend.pop_front();
          m_last  = m_frame;
          m_und   = 1'b0;
          m_real  = 1'b1;
        end else begin
          m_und  = 1'b1;
          m_real = 1'b0;
`ifdef DAC_TX_UNDERRUN_ZERO_EN
          m_frame = '0;
`else
          m_frame = m_last;
`endif
        end
      end else begin
        m_pos = m_pos + 1;
        m_und = 1'b0;
      end
      if (m_xfer) begin
        m_pend.push_back({leftIn, rightIn});
        m_xfers++;
      end
    end
  end

  // Per-cycle compare against the model, plus a loopback deserializer.
  // The deserializer uses the DUT's own framing strobes.
  logic        chk_en = 1'b0;
  logic [31:0] rx_sr  = '0;
  int          n_rx   = 0;

  always @(negedge BCLK) begin
    if (chk_en) begin
      check($sformatf("cycle pos%0d {ready,ser,lrck,wclk,und}", m_pos),
            {27'b0, sampleReady, serialOut, LRCK, WCLK, underrun},
            {27'b0, (m_pend.size() == 0), m_frame[31 - m_pos], (m_pos < 16),
             (m_pos == 15 || m_pos == 31), m_und});
      rx_sr = {rx_sr[30:0], serialOut};
      if (reset_n && WCLK && !LRCK && m_real) begin
        check("loopback pair", rx_sr, m_frame);
        n_rx++;
      end
    end
  end

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (m_pos != p) begin
      @(negedge BCLK);
      n++;
      if (n > 200) begin
        timeout("wait_pos");
        return;
      end
    end
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    leftIn      = l;
    rightIn     = r;
    sampleValid = 1'b1;
    @(negedge BCLK);
    sampleValid = 1'b0;
  endtask

  task automatic capture(output logic [31:0] f, output logic [31:0] wmask,
                         output logic [31:0] lmask, output int und);
    wait_pos(0);
    f = '0; wmask = '0; lmask = '0; und = 0;
    for (int i = 0; i < 32; i++) begin
      f        = {f[30:0], serialOut};
      wmask[i] = WCLK;
      lmask[i] = LRCK;
      und     += int'(underrun);
      @(negedge BCLK);
    end
  endtask

  initial begin
    logic [31:0] f, wm, lm;
    int          und, cyc, t_prev, n, und_cnt, base_x, base_rx;

    reset_n = 1'b1; sampleValid = 1'b0; leftIn = '0; rightIn = '0;
    #1 reset_n = 1'b0;
    #2;
    check("reset serialOut",   {31'b0, serialOut},   32'd0);
    check("reset LRCK",        {31'b0, LRCK},        32'd1);
    check("reset WCLK",        {31'b0, WCLK},        32'd0);
    check("reset underrun",    {31'b0, underrun},    32'd0);
    check("reset sampleReady", {31'b0, sampleReady}, 32'd1);
    chk_en = 1'b1;
    repeat (2) @(negedge BCLK);
    reset_n = 1'b1;

    // Single pair accepted mid-frame.
    wait_pos(5);
    send_pair(16'h8001, 16'h7FFE);
    capture(f, wm, lm, und);
    check("pair 8001/7FFE bits", f, 32'h8001_7FFE);
    check("pair WCLK bits",      wm, 32'h8000_8000);
    check("pair LRCK bits",      lm, 32'h0000_FFFF);
    check("pair no underrun",    und, 0);

    // Underrun after 1234/ABCD.
    wait_pos(8);
    send_pair(16'h1234, 16'hABCD);
    capture(f, wm, lm, und);
    check("pair 1234/ABCD bits", f, 32'h1234_ABCD);
    check("pair 1234 underruns", und, 0);
    capture(f, wm, lm, und);
    check("underrun frame bits", f, REPEAT_1234);
    check("underrun pulses",     und, 1);

    // Transfer on the boundary edge with hold empty.
    wait_pos(31);
    send_pair(16'hC3A5, 16'h5A3C);
    capture(f, wm, lm, und);
    check("boundary xfer: current frame", f, REPEAT_1234);
    check("boundary xfer: underrun",      und, 1);
    capture(f, wm, lm, und);
    check("boundary xfer: next frame",    f, 32'hC3A5_5A3C);
    check("boundary xfer: no underrun",   und, 0);

    // Streaming 8 pairs with sampleValid held high.
    sampleValid = 1'b1;
    cyc = 0; t_prev = 0; und_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      leftIn  = 16'($urandom);
      rightIn = 16'($urandom);
      n = 0;
      while (!sampleReady && n < 100) begin
        @(negedge BCLK);
        cyc++; n++;
        if (i > 0) und_cnt += int'(underrun);
      end
      if (n >= 100) timeout("stream ready");
      if (i > 0) check($sformatf("stream gap %0d", i), cyc - t_prev, 32);
      t_prev = cyc;
      @(negedge BCLK);
      cyc++;
      und_cnt += int'(underrun);
    end
    sampleValid = 1'b0;
    check("stream underruns", und_cnt, 0);
    wait_pos(0);
    check("stream last load underrun", {31'b0, underrun}, 32'd0);

    // Reset mid-frame with a pair buffered.
    wait_pos(3);
    send_pair(16'hDEAD, 16'hBEEF);
    wait_pos(20);
    #2 reset_n = 1'b0;
    #1;
    check("midreset serialOut",   {31'b0, serialOut},   32'd0);
    check("midreset LRCK",        {31'b0, LRCK},        32'd1);
    check("midreset WCLK",        {31'b0, WCLK},        32'd0);
    check("midreset underrun",    {31'b0, underrun},    32'd0);
    check("midreset sampleReady", {31'b0, sampleReady}, 32'd1);
    repeat (2) @(negedge BCLK);
    reset_n = 1'b1;
    capture(f, wm, lm, und);
    check("post-reset frame 0",     f, 32'h0);
    check("post-reset frame 0 und", und, 0);
    capture(f, wm, lm, und);
    check("post-reset frame 1",     f, 32'h0);
    check("post-reset frame 1 und", und, 1);

    // Randomized loopback of 1000 pairs.
    base_x  = m_xfers;
    base_rx = n_rx;
    n = 0;
    while ((m_xfers - base_x) < 1000 && n < 45000) begin
      sampleValid = ($urandom_range(0, 7) != 0);
      leftIn      = 16'($urandom);
      rightIn     = 16'($urandom);
      @(negedge BCLK);
      n++;
    end
    sampleValid = 1'b0;
    if (n >= 45000) timeout("loopback stream");
    repeat (100) @(negedge BCLK);
    check("loopback recovered count", n_rx - base_rx, 1000);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
